// File: rtl/out_rep_upload_buf.sv
// OUT_rep reply buffer: captures one reply message from the arbiter and replays it to the ring.
// Define OUT_REP_OVF_CHK_EN to drop flits past FLIT_DEPTH and raise a sticky ovf_err.
module out_rep_upload_buf #(
    parameter int FLIT_DEPTH = 11,
    parameter int PTR_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_in,
    input  logic [15:0] flit_in,
    input  logic [1:0]  ctrl_in,
    output logic        OUT_rep_rdy,
    output logic        v_rep_out,
    output logic [15:0] rep_flit_out,
    output logic [1:0]  rep_ctrl_out,
    input  logic        rep_ack,
    output logic        ovf_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SEND = 2'b10
    } state_t;

    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(FLIT_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FLIT_DEPTH - 1);

    state_t           state;
    state_t           next_state;
    logic [17:0]      mem [FLIT_DEPTH];
    logic [PTR_W-1:0] wr_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic             accept;
    logic             store;
    logic             eom;
    logic             full;
    logic             last_rd;

    assign full = (wr_cnt == FULL_CNT);

    // A tail ends a message, as does a head carrying a single-flit reply command.
    assign eom = (ctrl_in == 2'b11) ||
                 ((ctrl_in == 2'b01) &&
                  ((flit_in[9:5] == 5'b11100) || (flit_in[9:5] == 5'b10101)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        OUT_rep_rdy = 1'b0;
        v_rep_out   = 1'b0;
        accept      = 1'b0;
        last_rd     = 1'b0;
        case (state)
            IDLE: begin
                OUT_rep_rdy = 1'b1;
                accept      = en_in && (ctrl_in != 2'b00);
                if (accept && eom) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                v_rep_out = 1'b1;
                last_rd   = rep_ack && (rd_ptr == (wr_cnt - PTR_W'(1)));
                if (last_rd) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Without the overflow check, a full buffer keeps overwriting its last entry.
    always_comb begin
`ifdef OUT_REP_OVF_CHK_EN
        store = accept && !full;
`else
        store = accept;
`endif
        wr_idx = full ? LAST_IDX : wr_cnt;
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_idx] <= {ctrl_in, flit_in};
        end
    end

    assign {rep_ctrl_out, rep_flit_out} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_ptr <= '0;
        end else if (accept) begin
            if (!full) begin
                wr_cnt <= wr_cnt + PTR_W'(1);
            end
            if (eom) begin
                rd_ptr <= '0;
            end
        end else if (last_rd) begin
            wr_cnt <= '0;
            rd_ptr <= '0;
        end else if (v_rep_out && rep_ack) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

`ifdef OUT_REP_OVF_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (accept && full) begin
            ovf_err <= 1'b1;
        end
    end
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_out_rep_upload_buf.sv
// Self-checking bench for out_rep_upload_buf: directed scenarios plus random traffic
// compared against a queue-based message model.
module tb_out_rep_upload_buf;

    localparam int DEPTH = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic [15:0] flit_in;
    logic [1:0]  ctrl_in;
    logic        rep_ack;
    logic        OUT_rep_rdy;
    logic        v_rep_out;
    logic [15:0] rep_flit_out;
    logic [1:0]  rep_ctrl_out;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    logic [17:0] mq[$];
    bit          m_send;
    bit          m_ovf;
    logic [15:0] got[$];

    out_rep_upload_buf dut (
        .clk         (clk),
        .rst         (rst),
        .en_in       (en_in),
        .flit_in     (flit_in),
        .ctrl_in     (ctrl_in),
        .OUT_rep_rdy (OUT_rep_rdy),
        .v_rep_out   (v_rep_out),
        .rep_flit_out(rep_flit_out),
        .rep_ctrl_out(rep_ctrl_out),
        .rep_ack     (rep_ack),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    function automatic bit is_eom(input logic [1:0] c, input logic [15:0] f);
        return (c == 2'b11) || (c == 2'b01 && (f[9:5] == 5'b11100 || f[9:5] == 5'b10101));
    endfunction

    function automatic logic [17:0] exp_word();
        return (mq.size() > 0) ? mq[0] : 18'h0;
    endfunction

    // Applies one cycle of inputs at the falling edge, advances the message model
    // across the next rising edge, and returns at the following falling edge.
    task automatic drive(input logic r, input logic e, input logic [15:0] f,
                         input logic [1:0] c, input logic a);
        if (!r && v_rep_out && a) got.push_back(rep_flit_out);
        rst = r; en_in = e; flit_in = f; ctrl_in = c; rep_ack = a;
        if (r) begin
            mq.delete(); m_send = 0; m_ovf = 0;
        end else if (!m_send) begin
            if (e && c != 2'b00) begin
                if (mq.size() < DEPTH) mq.push_back({c, f});
`ifdef OUT_REP_OVF_CHK_EN
                else m_ovf = 1;
`else
                else mq[mq.size()-1] = {c, f};
`endif
                if (is_eom(c, f)) m_send = 1;
            end
        end else if (a) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_send = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 0, 16'h0, 2'b00, 0);
        drive(1, 1, 16'hFFFF, 2'b11, 1);
        checks++;
        if (OUT_rep_rdy !== 1'b1 || v_rep_out !== 1'b0 || ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: rdy=%b v=%b ovf=%b, want 1 0 0", OUT_rep_rdy, v_rep_out, ovf_err);
        end
        drive(0, 0, 16'h0, 2'b00, 1);
        checks++;
        if (OUT_rep_rdy !== 1'b1 || v_rep_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_ack: rdy=%b v=%b, want 1 0", OUT_rep_rdy, v_rep_out);
        end
    endtask

    task automatic test_long_msg();
        int vcount = 0;
        got.delete();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (OUT_rep_rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL long_fill_rdy flit %0d: rdy=%b, want 1", i, OUT_rep_rdy);
            end
            drive(0, 1, 16'h0100 + 16'(i), (i == 0) ? 2'b01 : (i == DEPTH-1) ? 2'b11 : 2'b10, 1);
        end
        checks++;
        if (OUT_rep_rdy !== 1'b0 || v_rep_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL long_after_tail: rdy=%b v=%b, want 0 1", OUT_rep_rdy, v_rep_out);
        end
        for (int cyc = 0; cyc < 20 && v_rep_out; cyc++) begin
            vcount++;
            checks++;
            if (OUT_rep_rdy !== ~m_send || v_rep_out !== m_send ||
                {rep_ctrl_out, rep_flit_out} !== exp_word()) begin
                errors++;
                $display("[TB] FAIL long_drain cyc %0d: rdy=%b v=%b word=%h, want rdy=%b v=%b word=%h",
                         cyc, OUT_rep_rdy, v_rep_out, {rep_ctrl_out, rep_flit_out}, ~m_send, m_send, exp_word());
            end
            drive(0, 0, 16'h0, 2'b00, 1);
        end
        checks++;
        if (vcount != DEPTH || OUT_rep_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL long_count: v cycles=%0d rdy=%b, want %0d 1", vcount, OUT_rep_rdy, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== 16'h0100 + 16'(i)) begin
                errors++;
                $display("[TB] FAIL long_order %0d: got=%h, want %h", i,
                         (i < got.size()) ? got[i] : 16'hxxxx, 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_single_flit();
        logic [4:0] cmds [2] = '{5'b10101, 5'b11100};
        for (int k = 0; k < 2; k++) begin
            logic [15:0] f;
            int vcount = 0;
            f = {6'($urandom), cmds[k], 5'($urandom)};
            got.delete();
            drive(0, 1, f, 2'b01, 1);
            for (int cyc = 0; cyc < 4; cyc++) begin
                if (v_rep_out) vcount++;
                drive(0, 0, 16'h0, 2'b00, 1);
            end
            checks++;
            if (vcount != 1 || got.size() != 1 || got[0] !== f || OUT_rep_rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_flit cmd %b: v cycles=%0d delivered=%0d first=%h rdy=%b, want 1 1 %h 1",
                         cmds[k], vcount, got.size(), (got.size() > 0) ? got[0] : 16'h0, OUT_rep_rdy, f);
            end
        end
    endtask

    task automatic test_no_eom_head();
        got.delete();
        drive(0, 1, 16'h0020, 2'b01, 1);
        for (int cyc = 0; cyc < 4; cyc++) begin
            checks++;
            if (OUT_rep_rdy !== 1'b1 || v_rep_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL plain_head cyc %0d: rdy=%b v=%b, want 1 0", cyc, OUT_rep_rdy, v_rep_out);
            end
            drive(0, 0, 16'h0, 2'b00, 1);
        end
        drive(0, 1, 16'h7777, 2'b11, 0);
        for (int cyc = 0; cyc < 4; cyc++) drive(0, 0, 16'h0, 2'b00, 1);
        checks++;
        if (got.size() != 2 || got[0] !== 16'h0020 || got[1] !== 16'h7777) begin
            errors++;
            $display("[TB] FAIL plain_head_drain: delivered=%0d, want 2 flits 0020 7777", got.size());
        end
    endtask

    task automatic test_backpressure();
        logic acks [6] = '{1, 0, 0, 1, 0, 1};
        got.delete();
        drive(0, 1, 16'h0040, 2'b01, 0);
        drive(0, 1, 16'hB0D1, 2'b10, 0);
        drive(0, 1, 16'h7A11, 2'b11, 0);
        for (int cyc = 0; cyc < 6; cyc++) begin
            checks++;
            if (v_rep_out !== m_send || {rep_ctrl_out, rep_flit_out} !== exp_word()) begin
                errors++;
                $display("[TB] FAIL backpressure cyc %0d: v=%b word=%h, want v=%b word=%h",
                         cyc, v_rep_out, {rep_ctrl_out, rep_flit_out}, m_send, exp_word());
            end
            drive(0, 0, 16'h0, 2'b00, acks[cyc]);
        end
        checks++;
        if (got.size() != 3 || got[0] !== 16'h0040 || got[1] !== 16'hB0D1 || got[2] !== 16'h7A11 ||
            OUT_rep_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL backpressure_total: delivered=%0d rdy=%b, want 3 1", got.size(), OUT_rep_rdy);
        end
    endtask

    task automatic test_send_ignores_en();
        got.delete();
        drive(0, 1, 16'h0060, 2'b01, 0);
        drive(0, 1, 16'h1234, 2'b11, 0);
        drive(0, 1, 16'hDEAD, 2'b11, 0);
        drive(0, 1, 16'hDEAD, 2'b10, 1);
        drive(0, 0, 16'h0, 2'b00, 1);
        drive(0, 1, 16'h02A0, 2'b01, 0);
        checks++;
        if (v_rep_out !== 1'b1 || rep_flit_out !== 16'h02A0 || rep_ctrl_out !== 2'b01) begin
            errors++;
            $display("[TB] FAIL send_ignores_en: v=%b word=%h, want v=1 word=102a0",
                     v_rep_out, {rep_ctrl_out, rep_flit_out});
        end
        drive(0, 0, 16'h0, 2'b00, 1);
        checks++;
        if (got.size() != 3 || got[0] !== 16'h0060 || got[1] !== 16'h1234 || got[2] !== 16'h02A0) begin
            errors++;
            $display("[TB] FAIL send_ignores_en_seq: delivered=%0d, want 3 flits 0060 1234 02a0", got.size());
        end
    endtask

    task automatic test_overflow();
        got.delete();
        for (int i = 0; i < 13; i++)
            drive(0, 1, 16'h0200 + 16'(i), (i == 0) ? 2'b01 : (i == 12) ? 2'b11 : 2'b10, 1);
        for (int cyc = 0; cyc < 20 && v_rep_out; cyc++) begin
            checks++;
            if (ovf_err !== m_ovf || {rep_ctrl_out, rep_flit_out} !== exp_word()) begin
                errors++;
                $display("[TB] FAIL overflow_drain cyc %0d: ovf=%b word=%h, want ovf=%b word=%h",
                         cyc, ovf_err, {rep_ctrl_out, rep_flit_out}, m_ovf, exp_word());
            end
            drive(0, 0, 16'h0, 2'b00, 1);
        end
        checks++;
        if (got.size() != DEPTH || got[DEPTH-2] !== 16'h0209
`ifdef OUT_REP_OVF_CHK_EN
            || got[DEPTH-1] !== 16'h020A || ovf_err !== 1'b1
`else
            || got[DEPTH-1] !== 16'h020C || ovf_err !== 1'b0
`endif
            ) begin
            errors++;
            $display("[TB] FAIL overflow_total: delivered=%0d last=%h ovf=%b", got.size(),
                     (got.size() > 0) ? got[got.size()-1] : 16'h0, ovf_err);
        end
        // A second oversized message, reset while it drains.
        for (int i = 0; i < 13; i++)
            drive(0, 1, 16'h0300 + 16'(i), (i == 0) ? 2'b01 : (i == 12) ? 2'b11 : 2'b10, 1);
        drive(0, 0, 16'h0, 2'b00, 1);
        drive(0, 0, 16'h0, 2'b00, 1);
        drive(1, 0, 16'h0, 2'b00, 1);
        checks++;
        if (v_rep_out !== 1'b0 || OUT_rep_rdy !== 1'b1 || ovf_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_drain: v=%b rdy=%b ovf=%b, want 0 1 0", v_rep_out, OUT_rep_rdy, ovf_err);
        end
        drive(0, 1, 16'h02A0, 2'b01, 0);
        checks++;
        if (v_rep_out !== 1'b1 || rep_flit_out !== 16'h02A0) begin
            errors++;
            $display("[TB] FAIL after_reset_msg: v=%b flit=%h, want 1 02a0", v_rep_out, rep_flit_out);
        end
        drive(0, 0, 16'h0, 2'b00, 1);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic        r, e, a;
            logic [15:0] f;
            logic [1:0]  c;
            int          p;
            checks++;
            if (OUT_rep_rdy !== ~m_send || v_rep_out !== m_send || ovf_err !== m_ovf ||
                (m_send && {rep_ctrl_out, rep_flit_out} !== exp_word())) begin
                errors++;
                $display("[TB] FAIL random cyc %0d: rdy=%b v=%b ovf=%b word=%h, want rdy=%b v=%b ovf=%b word=%h",
                         cyc, OUT_rep_rdy, v_rep_out, ovf_err, {rep_ctrl_out, rep_flit_out},
                         ~m_send, m_send, m_ovf, exp_word());
            end
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 75);
            a = ($urandom_range(0, 99) < 60);
            f = 16'($urandom);
            p = $urandom_range(0, 99);
            c = (p < 8) ? 2'b00 : (p < 22) ? 2'b01 : (p < 88) ? 2'b10 : 2'b11;
            if (c == 2'b01 && $urandom_range(0, 3) == 0) f[9:5] = $urandom_range(0, 1) ? 5'b10101 : 5'b11100;
            drive(r, e, f, c, a);
        end
    endtask

    initial begin
        rst = 1'b1; en_in = 1'b0; flit_in = '0; ctrl_in = '0; rep_ack = 1'b0;
        m_send = 0; m_ovf = 0;
        @(negedge clk);
        test_reset();
        test_long_msg();
        test_single_flit();
        test_no_eom_head();
        test_backpressure();
        test_send_ignores_en();
        test_overflow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
